// File: rtl/error_checker.sv
// Receive-side BERT checker: self-synchronises to the x^13+x^4+x^3+x+1 pattern,
// then counts received and errored bits in saturating counters while locked.
module error_checker #(
   parameter int unsigned LOCK_COUNT  = 4,
   parameter int unsigned LOSS_COUNT  = 4,
   parameter int unsigned LOSS_THRESH = 4,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [12:0]      rx_word,
   input  logic             rx_valid,
   input  logic             clear,
   output logic             locked,
   output logic             lock_lost,
   output logic             word_err,
   output logic [3:0]       err_bits,
   output logic [CNT_W-1:0] bit_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned WORD_W = 13;
   localparam int unsigned POP_W  = 4;
   localparam logic [POP_W-1:0] LOCK_CNT  = POP_W'(LOCK_COUNT);
   localparam logic [POP_W-1:0] LOSS_CNT  = POP_W'(LOSS_COUNT);
   localparam logic [POP_W-1:0] THRESH    = POP_W'(LOSS_THRESH);
   localparam logic [POP_W-1:0] WORD_BITS = POP_W'(WORD_W);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   expected_q, expected_d;
   logic                seeded_q, seeded_d;
   logic [POP_W-1:0]    match_cnt_q, match_cnt_d;
   logic [POP_W-1:0]    bad_cnt_q, bad_cnt_d;
   logic                lock_lost_q, lock_lost_d;
   logic                word_err_q, word_err_d;
   logic [POP_W-1:0]    err_bits_q, err_bits_d;
   logic [CNT_W-1:0]    bit_count_q, bit_count_d;
   logic [CNT_W-1:0]    err_count_q, err_count_d;

   logic [WORD_W-1:0]   err_vec;
   logic [POP_W-1:0]    err_pop;
   logic [POP_W-1:0]    match_inc;
   logic [POP_W-1:0]    bad_inc;
   logic                hunt_match;

   function automatic logic [WORD_W-1:0] lfsr_next(input logic [WORD_W-1:0] w);
      return {w[11:0], w[12] ^ w[3] ^ w[2] ^ w[0]};
   endfunction

   function automatic logic [POP_W-1:0] popcnt(input logic [WORD_W-1:0] v);
      logic [POP_W-1:0] s;
      s = '0;
      for (int i = 0; i < int'(WORD_W); i++) s = s + POP_W'(v[i]);
      return s;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [POP_W-1:0] inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, cnt} + (CNT_W+1)'(inc);
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= HUNT;
      else     state_q <= state_d;
   end

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      expected_d  = expected_q;
      seeded_d    = seeded_q;
      match_cnt_d = match_cnt_q;
      bad_cnt_d   = bad_cnt_q;
      lock_lost_d = 1'b0;
      word_err_d  = 1'b0;
      err_bits_d  = err_bits_q;
      bit_count_d = bit_count_q;
      err_count_d = err_count_q;

      err_vec    = rx_word ^ expected_q;
      err_pop    = popcnt(err_vec);
      match_inc  = match_cnt_q + POP_W'(1);
      bad_inc    = bad_cnt_q + POP_W'(1);
      hunt_match = seeded_q && (rx_word == expected_q) && (rx_word != '0);

      if (rx_valid) begin
         case (state_q)
            HUNT: begin
               // Always reseed from the received word while hunting
               expected_d = lfsr_next(rx_word);
               seeded_d   = 1'b1;
               if (hunt_match) begin
                  match_cnt_d = match_inc;
                  if (match_inc == LOCK_CNT) begin
                     state_d   = LOCKED;
                     bad_cnt_d = '0;
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end
            LOCKED: begin
               // Free-running reference so isolated bit errors never propagate
               expected_d = lfsr_next(expected_q);
               if (!clear) begin
                  err_bits_d  = err_pop;
                  word_err_d  = (err_pop != '0);
                  bit_count_d = sat_add(bit_count_q, WORD_BITS);
                  err_count_d = sat_add(err_count_q, err_pop);
               end
               if (err_pop > THRESH) begin
                  bad_cnt_d = bad_inc;
                  if (bad_inc == LOSS_CNT) begin
                     state_d     = HUNT;
                     match_cnt_d = '0;
                     seeded_d    = 1'b0;
                     bad_cnt_d   = '0;
                     lock_lost_d = 1'b1;
                  end
               end else begin
                  bad_cnt_d = '0;
               end
            end
            default: state_d = HUNT;
         endcase
      end

      if (clear) begin
         bit_count_d = '0;
         err_count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         expected_q  <= '0;
         seeded_q    <= 1'b0;
         match_cnt_q <= '0;
         bad_cnt_q   <= '0;
         lock_lost_q <= 1'b0;
         word_err_q  <= 1'b0;
         err_bits_q  <= '0;
         bit_count_q <= '0;
         err_count_q <= '0;
      end else begin
         expected_q  <= expected_d;
         seeded_q    <= seeded_d;
         match_cnt_q <= match_cnt_d;
         bad_cnt_q   <= bad_cnt_d;
         lock_lost_q <= lock_lost_d;
         word_err_q  <= word_err_d;
         err_bits_q  <= err_bits_d;
         bit_count_q <= bit_count_d;
         err_count_q <= err_count_d;
      end
   end

   // Output decode
   always_comb begin
      locked    = (state_q == LOCKED);
      lock_lost = lock_lost_q;
      word_err  = word_err_q;
      err_bits  = err_bits_q;
      bit_count = bit_count_q;
      err_count = err_count_q;
   end

endmodule

// File: tb/tb_error_checker.sv
// Scoreboard bench for error_checker: a 32-bit and an 8-bit counter instance
// share one stimulus stream; expected per-cycle outputs are queued and compared.
module tb_error_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [12:0] rx_word = '0;
   logic        rx_valid = 1'b0;
   logic        clear = 1'b0;

   logic        locked, lock_lost, word_err;
   logic [3:0]  err_bits;
   logic [31:0] bit_count, err_count;

   logic        locked8, lock_lost8, word_err8;
   logic [3:0]  err_bits8;
   logic [7:0]  bit_count8, err_count8;

   error_checker #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .rx_word(rx_word), .rx_valid(rx_valid), .clear(clear),
      .locked(locked), .lock_lost(lock_lost), .word_err(word_err), .err_bits(err_bits),
      .bit_count(bit_count), .err_count(err_count));

   error_checker #(.CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .rx_word(rx_word), .rx_valid(rx_valid), .clear(clear),
      .locked(locked8), .lock_lost(lock_lost8), .word_err(word_err8), .err_bits(err_bits8),
      .bit_count(bit_count8), .err_count(err_count8));

   always #5 clk = ~clk;

   typedef struct packed {
      logic        lk;
      logic        lost;
      logic        werr;
      logic [3:0]  ebits;
      logic [31:0] bits;
      logic [31:0] errs;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   // Bench-side intent: what the channel sends and what the checker should report
   logic [12:0] gen;
   logic        e_locked;
   logic [3:0]  e_ebits;
   logic [31:0] e_bits, e_errs;

   function automatic logic [12:0] pat_next(input logic [12:0] w);
      return {w[11:0], w[12] ^ w[3] ^ w[2] ^ w[0]};
   endfunction

   function automatic logic [31:0] sat8(input logic [31:0] v);
      return (v > 32'd255) ? 32'd255 : v;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic lost, input logic werr);
      exp_t r;
      r.lk    = e_locked;
      r.lost  = lost;
      r.werr  = werr;
      r.ebits = e_ebits;
      r.bits  = e_bits;
      r.errs  = e_errs;
      exp_q.push_back(r);
   endtask

   task automatic do_reset(input logic v);
      rst      = 1'b1;
      rx_valid = v;
      rx_word  = 13'h1abc;
      clear    = 1'b0;
      @(posedge clk);
      e_locked = 1'b0;
      e_ebits  = '0;
      e_bits   = '0;
      e_errs   = '0;
      push_exp(1'b0, 1'b0);
      #1;
      rst      = 1'b0;
      rx_valid = 1'b0;
   endtask

   // One cycle: channel word = pattern ^ mask; lk is the lock state the checker should hold afterwards
   task automatic send(input logic [12:0] mask, input logic v, input logic clr, input logic lk);
      int   pc;
      logic werr;
      logic lost;
      rx_word  = v ? (gen ^ mask) : 13'h0;
      rx_valid = v;
      clear    = clr;
      @(posedge clk);
      pc   = $countones(mask);
      werr = 1'b0;
      lost = v && e_locked && !lk;
      if (v && e_locked && !clr) begin
         e_bits  = e_bits + 32'd13;
         e_errs  = e_errs + 32'(pc);
         e_ebits = 4'(pc);
         werr    = (pc != 0);
      end
      if (clr) begin
         e_bits = '0;
         e_errs = '0;
      end
      e_locked = lk;
      push_exp(lost, werr);
      if (v) gen = pat_next(gen);
      #1;
      rx_valid = 1'b0;
      clear    = 1'b0;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t r;
         r = exp_q.pop_front();
         check_eq("locked",    32'(locked),     32'(r.lk));
         check_eq("lock_lost", 32'(lock_lost),  32'(r.lost));
         check_eq("word_err",  32'(word_err),   32'(r.werr));
         check_eq("err_bits",  32'(err_bits),   32'(r.ebits));
         check_eq("bit_count", bit_count,       r.bits);
         check_eq("err_count", err_count,       r.errs);
         check_eq("bit_count8", 32'(bit_count8), sat8(r.bits));
         check_eq("err_count8", 32'(err_count8), sat8(r.errs));
      end
   end

   initial begin
      gen = 13'h0001;
      do_reset(1'b0);
      do_reset(1'b0);

      // Lock-up on a clean stream, then 10 counted words
      gen = 13'h0001;
      for (int i = 0; i < 5; i++) send(13'h0, 1'b1, 1'b0, i == 4);
      for (int i = 0; i < 10; i++) send(13'h0, 1'b1, 1'b0, 1'b1);

      // Single-bit errors on every third word
      send(13'h0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 30; i++) send((i % 3 == 0) ? 13'h0001 : 13'h0, 1'b1, 1'b0, 1'b1);

      // Loss of lock after four 5-bit errored words, then relock
      send(13'h0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) send(13'h1f00, 1'b1, 1'b0, i < 3);
      for (int i = 0; i < 5; i++) send(13'h0, 1'b1, 1'b0, i == 4);

      // Gapped traffic, clear alongside an errored word, then clean words
      for (int i = 0; i < 6; i++) send(13'h0, (i % 2) == 0, 1'b0, 1'b1);
      send(13'h0004, 1'b1, 1'b1, 1'b1);
      send(13'h0, 1'b0, 1'b0, 1'b1);
      send(13'h0, 1'b1, 1'b0, 1'b1);
      send(13'h0, 1'b1, 1'b0, 1'b1);

      // All-zero stream never locks
      do_reset(1'b0);
      gen = 13'h0000;
      for (int i = 0; i < 20; i++) send(13'h0, 1'b1, 1'b0, 1'b0);

      // Saturation of the narrow counters, then reset mid-stream
      do_reset(1'b0);
      gen = 13'h0001;
      for (int i = 0; i < 5; i++) send(13'h0, 1'b1, 1'b0, i == 4);
      for (int i = 0; i < 22; i++) send(13'h0, 1'b1, 1'b0, 1'b1);
      do_reset(1'b1);
      gen = 13'h0001;
      for (int i = 0; i < 3; i++) send(13'h0, 1'b0, 1'b0, 1'b0);

      repeat (4) @(negedge clk);
      check_eq("drain", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/error_checker.md
# error_checker

Receive-side bit-error counter for the BERT datapath. Takes the 13-bit pattern words arriving from the channel and compares each one against a locally regenerated copy of the transmit LFSR sequence. It self-synchronises to the incoming stream, then counts received bits and errored bits in saturating counters for the display/readout logic. It sits directly after the error-injection channel and is the counterpart of the pattern transmitter.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive matching words required in HUNT to declare lock (1..15).
- LOSS_COUNT, 4: consecutive bad words in LOCKED required to drop lock (1..15).
- LOSS_THRESH, 4: a word is "bad" when err_bits > LOSS_THRESH (0..12).
- CNT_W, 32: width of bit_count and err_count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_word  in  13  received pattern word.
- rx_valid  in  1  rx_word is valid this cycle.
- clear  in  1  synchronous counter clear; lock state is unaffected.
- locked  out  1  high in LOCKED state.
- lock_lost  out  1  one-cycle pulse on a LOCKED→HUNT transition.
- word_err  out  1  one-cycle pulse: the last counted word had ≥1 bit error.
- err_bits  out  4  popcount of errors in the last counted word (0..13).
- bit_count  out  CNT_W  received bits counted while LOCKED.
- err_count  out  CNT_W  errored bits counted while LOCKED.

## Operation
- Pattern definition: next(W) = {W[11:0], W[12]^W[3]^W[2]^W[0]} (x^13+x^4+x^3+x+1, one shift per word). Examples: next(0x0001)=0x0003, next(0x0003)=0x0007, next(0x0007)=0x000E.
- Internal state: state {HUNT, LOCKED}, expected[12:0], seeded, match_cnt, bad_cnt.
- HUNT, on each rx_valid:
  - A match is seeded && rx_word==expected && rx_word!=0. A match increments match_cnt. Anything else sets match_cnt=0.
  - expected ← next(rx_word) and seeded ← 1; the checker always reseeds from received data.
  - When a match brings match_cnt to LOCK_COUNT: go to LOCKED, bad_cnt=0, and expected ← next(rx_word).
  - Nothing is counted in HUNT.
- LOCKED, on each rx_valid:
  - e = rx_word ^ expected.
  - expected ← next(expected). The checker is free-running and never reseeded from data, so single-bit errors do not propagate.
  - err_bits ← popcount(e); word_err ← (e!=0).
  - bit_count += 13 and err_count += popcount(e). Each counter saturates independently at all-ones; it never wraps.
  - If popcount(e) > LOSS_THRESH, bad_cnt++; otherwise bad_cnt=0.
  - When bad_cnt reaches LOSS_COUNT: go to HUNT, match_cnt=0, seeded=0, pulse lock_lost. This word's errors are still counted.
- rx_valid low: no state, counter, or expected change. word_err and lock_lost are low.
- clear=1: bit_count and err_count go to 0. If rx_valid is also high, clear wins and that word is not added to the counters, but lock/expected processing proceeds normally.
- rst=1: state=HUNT, seeded=0, match_cnt=0, bad_cnt=0, expected=0. All outputs are 0. rst takes priority over everything and applies mid-stream.

## Timing
- Latency is 1 cycle. Every effect of a word sampled with rx_valid at edge N is visible after edge N: locked, err_bits, word_err, counters, lock_lost.
- locked rises after the edge that sampled the LOCK_COUNT-th consecutive match. The minimum is LOCK_COUNT+1 valid words after reset (one seed word plus LOCK_COUNT matches).
- The first counted word is the first valid word after locked rises.
- err_bits holds its value until the next counted word. word_err and lock_lost are single-cycle pulses.
- Back-to-back rx_valid every cycle is supported. Arbitrary gaps in rx_valid are allowed.

## Test plan
- Lock-up: after reset, send a clean sequence 0x0001, 0x0003, 0x0007, 0x000E, 0x001C… one per cycle. Required: locked rises after the 5th word. Then, after 10 more clean words: bit_count=130, err_count=0, word_err never asserted.
- Single-bit errors: once locked, flip bit 0 of every 3rd word for 30 words. Required: err_count=10, bit_count=390, word_err pulses 10 times with err_bits=1, and locked stays high.
- Loss of lock: once locked, send 4 consecutive words XORed with 0x1F00 (5 bits each). Required: err_count=20, lock_lost pulses once after the 4th word, and locked=0. Resuming the clean sequence relocks after 5 words.
- All-zero stream: after reset, send 0x0000 for 20 cycles. Required: locked stays 0 and both counters stay 0.
- Clear and gaps: once locked, toggle rx_valid every other cycle, assert clear together with a valid errored word, then send 2 clean words. Required: counters read 0 after the clear cycle, then bit_count=26, err_count=0, and expected stays aligned (no errors).
- Saturation and reset: with CNT_W=8 and continuous clean locked words, bit_count stops at 255. Asserting rst mid-stream returns all outputs to 0 and state to HUNT on the next edge.
